// File: rtl/seg7_scan_decoder.sv
// Receive-side 7-segment scan decoder: samples a multiplexed display bus, decodes
// each digit's segment pattern to hex and commits a digit once it has been stable.
module seg7_scan_decoder #(
   parameter int unsigned DIGITS     = 4,
   parameter int unsigned STABLE_CNT = 3,
   localparam int unsigned IDX_W     = $clog2(DIGITS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_sample_en,
   input  logic [7:0]            i_seg_in,
   input  logic [DIGITS-1:0]     i_an_in,
   output logic [4*DIGITS-1:0]   o_digit_val,
   output logic [DIGITS-1:0]     o_digit_dp,
   output logic [DIGITS-1:0]     o_digit_valid,
   output logic                  o_upd,
   output logic [IDX_W-1:0]      o_upd_idx,
   output logic                  o_err,
   output logic                  o_an_err
);

   localparam int unsigned CNT_W = $clog2(STABLE_CNT + 1);
   localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CNT);

   logic [3:0]       r_cand_val  [DIGITS];
   logic             r_cand_dp   [DIGITS];
   logic [CNT_W-1:0] r_cnt       [DIGITS];
   logic [3:0]       r_digit_val [DIGITS];
   logic [DIGITS-1:0] r_digit_dp;
   logic [DIGITS-1:0] r_digit_valid;
   logic             r_upd;
   logic [IDX_W-1:0] r_upd_idx;
   logic             r_err;
   logic             r_an_err;

   logic             w_an_any;
   logic             w_an_multi;
   logic [IDX_W-1:0] w_idx;
   logic [3:0]       w_dec_val;
   logic             w_dec_ok;
   logic             w_blank;
   logic             w_dp;
   logic             w_same;
   logic [CNT_W-1:0] w_new_cnt;
   logic             w_reach;
   logic             w_changed;
   logic             w_act;

   assign w_an_any   = |i_an_in;
   assign w_an_multi = (i_an_in & (i_an_in - DIGITS'(1))) != '0;
   assign w_act      = i_sample_en && w_an_any && !w_an_multi;
   assign w_blank    = i_seg_in[7:1] == 7'b0000000;
   assign w_dp       = i_seg_in[0];

   always_comb begin
      w_idx = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (i_an_in[i]) w_idx = IDX_W'(i);
      end
   end

   always_comb begin
      w_dec_ok  = 1'b1;
      w_dec_val = 4'h0;
      case (i_seg_in[7:1])
         7'b1111110: w_dec_val = 4'h0;
         7'b0110000: w_dec_val = 4'h1;
         7'b1101101: w_dec_val = 4'h2;
         7'b1111001: w_dec_val = 4'h3;
         7'b0110011: w_dec_val = 4'h4;
         7'b1011011: w_dec_val = 4'h5;
         7'b1011111: w_dec_val = 4'h6;
         7'b1110000: w_dec_val = 4'h7;
         7'b1111111: w_dec_val = 4'h8;
         7'b1111011: w_dec_val = 4'h9;
         7'b1110111: w_dec_val = 4'hA;
         7'b0011111: w_dec_val = 4'hB;
         7'b1001110: w_dec_val = 4'hC;
         7'b0111101: w_dec_val = 4'hD;
         7'b1001111: w_dec_val = 4'hE;
         7'b1000111: w_dec_val = 4'hF;
         default:    w_dec_ok  = 1'b0;
      endcase
   end

   // Commit fires only on the transition into STABLE, not while saturated there.
   always_comb begin
      w_same = {w_dec_val, w_dp} == {r_cand_val[w_idx], r_cand_dp[w_idx]};
      if (!w_same) begin
         w_new_cnt = CNT_W'(1);
      end else if (r_cnt[w_idx] < STABLE) begin
         w_new_cnt = r_cnt[w_idx] + CNT_W'(1);
      end else begin
         w_new_cnt = r_cnt[w_idx];
      end
      w_reach   = (w_new_cnt == STABLE) && (!w_same || (r_cnt[w_idx] != STABLE));
      w_changed = !r_digit_valid[w_idx] ||
                  ({r_digit_val[w_idx], r_digit_dp[w_idx]} != {w_dec_val, w_dp});
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DIGITS; i++) begin
            r_cand_val[i]  <= 4'h0;
            r_cand_dp[i]   <= 1'b0;
            r_cnt[i]       <= '0;
            r_digit_val[i] <= 4'h0;
         end
         r_digit_dp    <= '0;
         r_digit_valid <= '0;
         r_upd         <= 1'b0;
         r_upd_idx     <= '0;
         r_err         <= 1'b0;
         r_an_err      <= 1'b0;
      end else begin
         r_upd    <= 1'b0;
         r_err    <= 1'b0;
         r_an_err <= i_sample_en && w_an_multi;
         if (w_act) begin
            if (w_blank) begin
               r_cnt[w_idx] <= '0;
            end else if (!w_dec_ok) begin
               r_err        <= 1'b1;
               r_cnt[w_idx] <= '0;
            end else begin
               r_cand_val[w_idx] <= w_dec_val;
               r_cand_dp[w_idx]  <= w_dp;
               r_cnt[w_idx]      <= w_new_cnt;
               if (w_reach && w_changed) begin
                  r_digit_val[w_idx]   <= w_dec_val;
                  r_digit_dp[w_idx]    <= w_dp;
                  r_digit_valid[w_idx] <= 1'b1;
                  r_upd                <= 1'b1;
                  r_upd_idx            <= w_idx;
               end
            end
         end
      end
   end

   always_comb begin
      o_digit_val = '0;
      for (int i = 0; i < DIGITS; i++) begin
         o_digit_val[4*i +: 4] = r_digit_val[i];
      end
   end

   assign o_digit_dp    = r_digit_dp;
   assign o_digit_valid = r_digit_valid;
   assign o_upd         = r_upd;
   assign o_upd_idx     = r_upd_idx;
   assign o_err         = r_err;
   assign o_an_err      = r_an_err;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: per-cycle comparison against a table-driven model
// plus directed scenarios with literal expectations.
module tb_seg7_scan_decoder;

   localparam int DIGITS = 4;
   localparam int S      = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sample_en = 1'b0;
   logic [7:0]  seg_in = 8'h00;
   logic [3:0]  an_in = 4'h0;
   logic [15:0] digit_val;
   logic [3:0]  digit_dp;
   logic [3:0]  digit_valid;
   logic        upd;
   logic [1:0]  upd_idx;
   logic        err;
   logic        an_err;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   logic [6:0] tbl [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                            7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                            7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                            7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

   seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE_CNT(S)) dut (
      .clk           (clk),
      .rst           (rst),
      .i_sample_en   (sample_en),
      .i_seg_in      (seg_in),
      .i_an_in       (an_in),
      .o_digit_val   (digit_val),
      .o_digit_dp    (digit_dp),
      .o_digit_valid (digit_valid),
      .o_upd         (upd),
      .o_upd_idx     (upd_idx),
      .o_err         (err),
      .o_an_err      (an_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model state: each digit's candidate/committed as key = value*2 + dp.
   int m_cand  [DIGITS];
   int m_cnt   [DIGITS];
   int m_comm  [DIGITS];
   bit m_valid [DIGITS];
   bit e_upd, e_err, e_aerr;
   int e_idx;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DIGITS; i++) begin
            m_cand[i] = 0; m_cnt[i] = 0; m_comm[i] = 0; m_valid[i] = 0;
         end
         e_upd = 0; e_err = 0; e_aerr = 0; e_idx = 0;
      end else begin
         int d, v, key;
         bit reached;
         e_upd = 0; e_err = 0; e_aerr = 0;
         if (sample_en && $countones(an_in) > 1) begin
            e_aerr = 1;
         end else if (sample_en && $countones(an_in) == 1) begin
            d = 0;
            for (int i = 0; i < DIGITS; i++) if (an_in[i]) d = i;
            v = -1;
            for (int k = 0; k < 16; k++) if (tbl[k] == seg_in[7:1]) v = k;
            if (seg_in[7:1] == 7'd0) begin
               m_cnt[d] = 0;
            end else if (v < 0) begin
               e_err = 1;
               m_cnt[d] = 0;
            end else begin
               key = v * 2 + int'(seg_in[0]);
               reached = 0;
               if (key == m_cand[d]) begin
                  if (m_cnt[d] < S) begin
                     m_cnt[d]++;
                     reached = (m_cnt[d] == S);
                  end
               end else begin
                  m_cand[d] = key;
                  m_cnt[d] = 1;
                  reached = (S == 1);
               end
               if (reached && (!m_valid[d] || m_comm[d] != key)) begin
                  m_comm[d] = key; m_valid[d] = 1; e_upd = 1; e_idx = d;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en && !rst) begin
         for (int i = 0; i < DIGITS; i++) begin
            check($sformatf("model_val%0d", i), int'(digit_val[4*i +: 4]),
                  m_valid[i] ? m_comm[i] / 2 : 0);
            check($sformatf("model_dp%0d", i), int'(digit_dp[i]),
                  m_valid[i] ? m_comm[i] % 2 : 0);
            check($sformatf("model_valid%0d", i), int'(digit_valid[i]), int'(m_valid[i]));
         end
         check("model_upd", int'(upd), int'(e_upd));
         if (e_upd) check("model_upd_idx", int'(upd_idx), e_idx);
         check("model_err", int'(err), int'(e_err));
         check("model_an_err", int'(an_err), int'(e_aerr));
      end
   end

   task automatic strobe(input logic [3:0] an, input logic [7:0] seg);
      @(negedge clk);
      sample_en = 1'b1; an_in = an; seg_in = seg;
      @(negedge clk);
      sample_en = 1'b0; an_in = 4'h0; seg_in = 8'h00;
   endtask

   int exp_upd3 [5] = '{0, 0, 0, 0, 1};

   initial begin
      repeat (3) @(negedge clk);
      check("reset_val", int'(digit_val), 0);
      check("reset_valid", int'(digit_valid), 0);
      check("reset_pulses", int'({upd, err, an_err}), 0);
      rst = 1'b0;
      chk_en = 1'b1;

      // Stable commit of 5 on digit 0
      for (int n = 0; n < 3; n++) begin
         strobe(4'b0001, 8'b10110110);
         if (n < 2) check("t2_no_upd_early", int'(upd), 0);
      end
      check("t2_val", int'(digit_val[3:0]), 5);
      check("t2_valid", int'(digit_valid[0]), 1);
      check("t2_upd", int'(upd), 1);
      check("t2_idx", int'(upd_idx), 0);
      strobe(4'b0001, 8'b10110110);
      check("t2_saturated_no_upd", int'(upd), 0);

      // Flicker 2,2,3,3,3 on digit 1
      for (int n = 0; n < 5; n++) begin
         strobe(4'b0010, (n < 2) ? 8'b11011010 : 8'b11110010);
         check("t3_upd_seq", int'(upd), exp_upd3[n]);
         if (n < 4) check("t3_not_valid", int'(digit_valid[1]), 0);
      end
      check("t3_val", int'(digit_val[7:4]), 3);
      check("t3_idx", int'(upd_idx), 1);

      // Invalid then blank on committed digit 0
      strobe(4'b0001, 8'b00000010);
      check("t4_err", int'(err), 1);
      check("t4_val_kept", int'(digit_val[3:0]), 5);
      strobe(4'b0001, 8'b00000000);
      check("t4_blank_no_err", int'(err), 0);
      for (int n = 0; n < 3; n++) begin
         strobe(4'b0001, 8'b10110110);
         check("t4_same_no_upd", int'(upd), 0);
      end

      // Multi-hot select must not disturb digit 0 or digit 1 progress
      strobe(4'b0001, 8'b11110110);
      strobe(4'b0001, 8'b11110110);
      strobe(4'b0010, 8'b11100000);
      strobe(4'b0011, 8'b11100000);
      check("t5_an_err", int'(an_err), 1);
      check("t5_no_err", int'(err), 0);
      strobe(4'b0001, 8'b11110110);
      check("t5_d0_upd", int'(upd), 1);
      check("t5_d0_val", int'(digit_val[3:0]), 9);
      strobe(4'b0010, 8'b11100000);
      check("t5_d1_no_upd", int'(upd), 0);
      strobe(4'b0010, 8'b11100000);
      check("t5_d1_upd", int'(upd), 1);
      check("t5_d1_val", int'(digit_val[7:4]), 7);

      // dp change on digit 2
      repeat (3) strobe(4'b0100, 8'b11111110);
      check("t6_first_val", int'(digit_val[11:8]), 8);
      repeat (3) strobe(4'b0100, 8'b11111111);
      check("t6_upd", int'(upd), 1);
      check("t6_idx", int'(upd_idx), 2);
      check("t6_dp", int'(digit_dp[2]), 1);
      check("t6_val", int'(digit_val[11:8]), 8);

      // Full decode table on digit 3
      for (int v = 0; v < 16; v++) begin
         logic [7:0] pat;
         pat = {tbl[v], v[0]};
         repeat (3) strobe(4'b1000, pat);
         check($sformatf("sweep_val_%0d", v), int'(digit_val[15:12]), v);
         check($sformatf("sweep_upd_%0d", v), int'(upd), 1);
      end

      // Asynchronous reset mid-run, then fresh commit needs three samples
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("t1_async_val", int'(digit_val), 0);
      check("t1_async_valid", int'(digit_valid), 0);
      check("t1_async_dp", int'(digit_dp), 0);
      @(negedge clk);
      rst = 1'b0;
      strobe(4'b0001, 8'b10110110);
      strobe(4'b0001, 8'b10110110);
      check("t1_not_yet", int'(digit_valid[0]), 0);
      strobe(4'b0001, 8'b10110110);
      check("t1_recommit", int'(upd), 1);
      check("t1_val", int'(digit_val[3:0]), 5);

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
